// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the counter and display family.
// Pure definitions: no latency, no flow control.
package bcd_pkg;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with borrow ripple to the next digit.
// Latency: one falling edge per load/decrement; no backpressure, dec_in is a plain enable.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       dec_in,
    input  logic       wrap_en,
    output logic [3:0] q,
    output logic       dec_out
);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= bcd_clamp(load_digit);
        end else if (dec_in) begin
            // A zero digit either borrows round to 9 or, when wrapping is gated off, sticks at 0.
            if (q == BCD_ZERO) q <= wrap_en ? BCD_MAX : BCD_ZERO;
            else               q <= q - 4'd1;
        end
    end

    assign dec_out = dec_in & (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with load, wrap/hold at zero, zero flag and cascade borrow.
// Latency: one falling edge per step; zero/borrow_out are combinational; no backpressure.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                en,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                borrow_out,
    output logic                done
);

    localparam logic [4*DIGITS-1:0] COUNT_ONE = 1;

    logic [DIGITS:0] dec;
    logic            wrap_en;

    assign dec[0]  = en & ~load;
    // Only a counter already at zero can reach the wrap path; hold there unless wrapping.
    assign wrap_en = WRAP | ~zero;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .dec_in     (dec[i]),
            .wrap_en    (wrap_en),
            .q          (count[4*i +: 4]),
            .dec_out    (dec[i+1])
        );
    end

    assign zero       = (count == '0);
    // Borrow that rippled past the top digit equals en & ~load & zero.
    assign borrow_out = dec[DIGITS];

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) done <= 1'b0;
        else      done <= en & ~load & (count == COUNT_ONE);
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench: driver queues expected results, monitor compares after each falling edge.
module tb_bcd_down_counter;

    logic clk = 1'b1;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       d0_load = 0, d0_en = 0, d0_zero, d0_bo, d0_done;
    logic [7:0] d0_lv = 0, d0_cnt;
    logic       d1_load = 0, d1_en = 0, d1_zero, d1_bo, d1_done;
    logic [7:0] d1_lv = 0, d1_cnt;
    logic        c_load = 0, c_en = 0;
    logic [15:0] c_lv = 0;
    logic [7:0]  lo_cnt, hi_cnt;
    logic        lo_zero, lo_bo, lo_done, hi_zero, hi_bo, hi_done;

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .load(d0_load), .load_val(d0_lv), .en(d0_en),
        .count(d0_cnt), .zero(d0_zero), .borrow_out(d0_bo), .done(d0_done));

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_hold (
        .clk(clk), .rst(rst), .load(d1_load), .load_val(d1_lv), .en(d1_en),
        .count(d1_cnt), .zero(d1_zero), .borrow_out(d1_bo), .done(d1_done));

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .load(c_load), .load_val(c_lv[7:0]), .en(c_en),
        .count(lo_cnt), .zero(lo_zero), .borrow_out(lo_bo), .done(lo_done));

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .load(c_load), .load_val(c_lv[15:8]), .en(lo_bo),
        .count(hi_cnt), .zero(hi_zero), .borrow_out(hi_bo), .done(hi_done));

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] cnt;
        logic        done;
        logic        bo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic step(input int sel, input logic ld, input logic [15:0] lv, input logic e,
                        input logic [15:0] ec, input logic ed, input logic eb, input string nm);
        exp_t it;
        @(posedge clk); #1;
        d0_load = 0; d0_en = 0; d1_load = 0; d1_en = 0; c_load = 0; c_en = 0;
        case (sel)
            0:       begin d0_load = ld; d0_lv = lv[7:0]; d0_en = e; end
            1:       begin d1_load = ld; d1_lv = lv[7:0]; d1_en = e; end
            default: begin c_load  = ld; c_lv  = lv;      c_en  = e; end
        endcase
        it.name = nm; it.sel = sel; it.cnt = ec; it.done = ed; it.bo = eb;
        sb.push_back(it);
    endtask

    task automatic chk_reset(input string nm);
        total++;
        if (d0_cnt !== 8'h00 || d0_zero !== 1'b1 || d0_done !== 1'b0) begin
            bad++;
            $display("FAIL %s: count=%h zero=%b done=%b, want count=00 zero=1 done=0",
                     nm, d0_cnt, d0_zero, d0_done);
        end
    endtask

    task automatic mid_reset(input string nm);
        @(posedge clk); #1;
        d0_load = 0; d0_en = 0; d1_load = 0; d1_en = 0; c_load = 0; c_en = 0;
        rst = 1'b0;
        #1 chk_reset(nm);
        #1 rst = 1'b1;
    endtask

    // Monitor: borrow_out sampled mid-cycle with the new inputs, registered outputs after the edge.
    initial begin
        exp_t        it;
        logic        bo_s, dn_s, z_s;
        logic [15:0] c_s;
        forever begin
            @(posedge clk); #3;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                bo_s = (it.sel == 0) ? d0_bo : (it.sel == 1) ? d1_bo : lo_bo;
                @(negedge clk); #1;
                case (it.sel)
                    0:       begin c_s = {8'h00, d0_cnt}; dn_s = d0_done; z_s = d0_zero; end
                    1:       begin c_s = {8'h00, d1_cnt}; dn_s = d1_done; z_s = d1_zero; end
                    default: begin c_s = {hi_cnt, lo_cnt}; dn_s = hi_done; z_s = hi_zero & lo_zero; end
                endcase
                total++;
                if (c_s !== it.cnt || dn_s !== it.done || z_s !== (it.cnt == 16'h0) || bo_s !== it.bo) begin
                    bad++;
                    $display("FAIL %s: count=%h done=%b zero=%b borrow=%b, want count=%h done=%b zero=%b borrow=%b",
                             it.name, c_s, dn_s, z_s, bo_s, it.cnt, it.done, (it.cnt == 16'h0), it.bo);
                end
            end
        end
    end

    initial begin
        int          m;
        logic        ld, e, eb, ed;
        logic [7:0]  lv;
        int          hi, lo;

        #8 chk_reset("por");
        #4 rst = 1'b1;

        // Reset mid-count at 37
        step(0, 1, 16'h37, 0, 16'h37, 0, 0, "ld37");
        step(0, 0, 0, 1, 16'h36, 0, 0, "dn36");
        mid_reset("rst_mid");

        // Load 12 and count to zero; done pulses only on reaching 00
        step(0, 1, 16'h12, 0, 16'h12, 0, 0, "ld12");
        for (int k = 11; k >= 0; k--)
            step(0, 0, 0, 1, to_bcd(k), (k == 0), 0, $sformatf("dn%0d", k));
        step(0, 0, 0, 0, 16'h00, 0, 0, "idle0");
        step(0, 0, 0, 1, 16'h99, 0, 1, "wrap99");

        // Clamping and load priority
        step(0, 1, 16'hA7, 0, 16'h97, 0, 0, "clampA7");
        step(0, 1, 16'h50, 1, 16'h50, 0, 0, "ld_over_en");
        step(0, 0, 0, 0, 16'h50, 0, 0, "hold50");
        step(0, 0, 0, 1, 16'h49, 0, 0, "dn49");
        step(0, 1, 16'hFF, 0, 16'h99, 0, 0, "clampFF");
        step(0, 1, 16'h9A, 0, 16'h99, 0, 0, "clamp9A");
        step(0, 1, 16'h00, 1, 16'h00, 0, 0, "ld0_en");

        // Pending done cancelled by reset
        step(0, 1, 16'h01, 0, 16'h01, 0, 0, "ld01");
        step(0, 0, 0, 1, 16'h00, 1, 0, "done01");
        mid_reset("rst_done");

        // WRAP = 0 holds at zero with borrow each enabled cycle
        step(1, 1, 16'h01, 0, 16'h01, 0, 0, "h_ld01");
        step(1, 0, 0, 1, 16'h00, 1, 0, "h_dn00");
        step(1, 0, 0, 1, 16'h00, 0, 1, "h_hold1");
        step(1, 0, 0, 1, 16'h00, 0, 1, "h_hold2");
        step(1, 1, 16'h20, 0, 16'h20, 0, 0, "h_ld20");
        step(1, 0, 0, 1, 16'h19, 0, 0, "h_dn19");

        // Cascade 0100 -> 0099 -> 0098
        step(2, 1, 16'h0100, 0, 16'h0100, 0, 0, "c_ld");
        step(2, 0, 0, 1, 16'h0099, 1, 1, "c_dn99");
        step(2, 0, 0, 1, 16'h0098, 0, 0, "c_dn98");

        // Random regression against a decimal model
        step(0, 1, 16'h55, 0, 16'h55, 0, 0, "r_ld55");
        m = 55;
        for (int i = 0; i < 2000; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            lv = 8'($urandom);
            eb = e & ~ld & (m == 0);
            ed = e & ~ld & (m == 1);
            if (ld) begin
                hi = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
                lo = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
                m  = hi * 10 + lo;
            end else if (e) begin
                m = (m == 0) ? 99 : m - 1;
            end
            step(0, ld, {8'h00, lv}, e, to_bcd(m), ed, eb, "rand");
        end

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected results left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

- Parameterised multi-digit BCD down counter: the count-down counterpart of the team's BCD up/ripple counters.
- Supports parallel load, count enable, optional wrap from 00 to 99…9, a zero flag and a cascadable borrow output.
- Drives countdown/timer displays and chains with further instances through `borrow_out`.
- All state is synchronous to the falling edge of `clk`, matching the team's counter family.

## Interface

Parameters:
- `DIGITS`, default 2: number of BCD digits, range 1–8.
- `WRAP`, default 1: 1 = count 0 wraps to all-9s; 0 = count holds at 0.

Ports:
- `clk`, input, 1: clock. All state updates on the falling edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `load`, input, 1: parallel-load strobe.
- `load_val`, input, 4*DIGITS: BCD load value. Digit 0 = bits [3:0].
- `en`, input, 1: count enable, one decrement per enabled falling edge.
- `count`, output, 4*DIGITS: current BCD value, registered.
- `zero`, output, 1: combinational, `count == 0`.
- `borrow_out`, output, 1: combinational, `en & zero & ~load`. Feeds `en` of the next, more significant instance.
- `done`, output, 1: registered one-cycle pulse, described under Operation.

## Operation

- **Reset (`rst` = 0):**
  - Immediate, independent of `clk`.
  - `count` = 0, `done` = 0, so `zero` = 1.
  - `borrow_out` follows `en & ~load`.
- **Priority** on each falling edge: reset > `load` > `en` > hold.
- **Load:**
  - `count` ← `load_val` digit-wise.
  - Any nibble > 9 is clamped to 9; other digits are unaffected.
  - `done` ← 0.
- **Decrement (`en` = 1, `load` = 0, `count` ≠ 0):**
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and propagates a borrow to the next digit.
  - A digit decrements only if every lower digit was 0.
  - `done` ← 1 exactly when the new `count` is 0, i.e. the old count was 1; otherwise `done` ← 0.
- **At zero (`en` = 1, `load` = 0, `count` = 0):**
  - `WRAP` = 1: `count` ← all digits 9.
  - `WRAP` = 0: `count` holds at 0.
  - `done` ← 0 in both cases.
  - `borrow_out` = 1 during this cycle.
- **Idle (`en` = 0, `load` = 0):** `count` holds, `done` ← 0.
- **Invariant:** `count` never holds a nibble > 9, under any input sequence.

## Timing

- Load latency: `load_val` is visible on `count` after the first falling edge with `load` = 1.
- Decrement latency: one falling edge per step.
- `zero` and `borrow_out` are combinational from `count`/`en`/`load`, with no register stage. A cascade of N instances therefore steps together on one edge.
- `done` is high for exactly one clock period, from the falling edge that reaches 0 to the next falling edge.
- Reset asserted mid-count:
  - Outputs clear within the same cycle.
  - A pending `done` pulse is cancelled.
- Reset release: the first edge after deassertion is honoured normally. `rst` must be deasserted away from the falling edge of `clk`.
- `load` and `en` asserted together: load wins, no decrement that cycle, `borrow_out` = 0.

## Structure

- **Shared package `bcd_pkg`:**
  - Constants `BCD_MAX` = 4'd9 and `BCD_ZERO` = 4'd0.
  - Function `bcd_clamp(nibble)`, returning min(nibble, 9).
  - These are reused by the up-counter and display blocks.
- **Sub-module `bcd_digit_down`:** one digit.
  - Inputs: `clk`, `rst`, `load`, `load_digit`, `dec_in`, `wrap_en`.
  - Outputs: `q[3:0]`, `dec_out`, where `dec_out` = `dec_in & (q == 0)`.
- **Top level:**
  - Generate-chains `DIGITS` instances.
  - Derives `zero` from all `q`.
  - Gates the wrap/hold decision for the `WRAP` = 0 case.
  - Holds the `done` register.

## Test plan

1. **Reset:** assert `rst` = 0 mid-count at value 37, with `DIGITS` = 2 → `count` = 00, `zero` = 1 and `done` = 0 before the next clock edge.
2. **Load and count to zero:**
   - Load 12, then `en` = 1 for 12 edges → sequence 11, 10, 09, …, 01, 00.
   - `done` pulses exactly once, on the edge reaching 00.
   - `zero` = 1 from then on.
3. **Wrap and hold:**
   - `WRAP` = 1: at 00 with `en` = 1 → `borrow_out` = 1, next `count` = 99, `done` = 0.
   - `WRAP` = 0: same stimulus → `count` stays 00 and `borrow_out` = 1 each enabled cycle.
4. **Load clamping and priority:**
   - Load 0xA7 → `count` = 97.
   - `load` = 1 with `en` = 1 and `load_val` = 0x50 → `count` = 50, no decrement, `borrow_out` = 0.
5. **Cascade:** two instances (`DIGITS` = 2 each) chained via `borrow_out` → `en`, upper loaded 01, lower loaded 00, `en` = 1 → combined value 0100 steps to 0099 on a single edge.
6. **Random regression:** random `load`/`en`/`load_val` for 2000 cycles against a decimal reference model → `count` always matches, and no nibble ever exceeds 9.
